// File: rtl/nios_led_onchip_mem_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the single-port on-chip RAM, with read-return routing.
// Optional build macro NIOS_LED_ARB_M0_PRIORITY_EN selects fixed m0 priority instead of round-robin.
module nios_led_onchip_mem_arbiter #(
   parameter  int ADDR_W = 12,
   parameter  int DATA_W = 32,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic r_ready;
   logic r_last_grant;
   logic r_rd_pend;
   logic r_rd_owner;

   logic w_req0;
   logic w_req1;
   logic w_grant0;
   logic w_grant1;
   logic w_rd_accept;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (r_ready) begin
         if (w_req0 && w_req1) begin
`ifdef NIOS_LED_ARB_M0_PRIORITY_EN
            w_grant0 = 1'b1;
`else
            // last_grant resets to 1 so the first conflict goes to m0
            if (r_last_grant) begin
               w_grant0 = 1'b1;
            end else begin
               w_grant1 = 1'b1;
            end
`endif
         end else begin
            w_grant0 = w_req0;
            w_grant1 = w_req1;
         end
      end
   end

   assign m0_waitrequest = ~w_grant0;
   assign m1_waitrequest = ~w_grant1;

   always_comb begin
      mem_address    = '0;
      mem_write      = 1'b0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      if (w_grant0) begin
         mem_address    = m0_address;
         mem_write      = m0_write;
         mem_byteenable = m0_byteenable;
         mem_writedata  = m0_writedata;
      end else if (w_grant1) begin
         mem_address    = m1_address;
         mem_write      = m1_write;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
      end
   end

   assign mem_chipselect = w_grant0 | w_grant1;
   assign mem_clken      = 1'b1;

   // A read that also asserts write is serviced as a write only
   assign w_rd_accept = (w_grant0 & m0_read & ~m0_write) |
                        (w_grant1 & m1_read & ~m1_write);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready      <= 1'b0;
         r_last_grant <= 1'b1;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= 1'b0;
      end else begin
         r_ready   <= 1'b1;
         r_rd_pend <= w_rd_accept;
         if (w_grant0 | w_grant1) begin
            r_last_grant <= w_grant1;
         end
         if (w_rd_accept) begin
            r_rd_owner <= w_grant1;
         end
      end
   end

   assign m0_readdatavalid = r_rd_pend & ~r_rd_owner;
   assign m1_readdatavalid = r_rd_pend &  r_rd_owner;
   assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
   assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_nios_led_onchip_mem_arbiter.sv
// Directed bench for nios_led_onchip_mem_arbiter with a behavioural 4096x32 RAM on the mem_* side.
// Arbitration expectations follow NIOS_LED_ARB_M0_PRIORITY_EN when it is defined.
module tb_nios_led_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] m0_address = '0;
   logic        m0_read = 1'b0;
   logic        m0_write = 1'b0;
   logic [3:0]  m0_byteenable = '0;
   logic [31:0] m0_writedata = '0;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;
   logic [11:0] m1_address = '0;
   logic        m1_read = 1'b0;
   logic        m1_write = 1'b0;
   logic [3:0]  m1_byteenable = '0;
   logic [31:0] m1_writedata = '0;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;
   logic [11:0] mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata = '0;

   int checks = 0;
   int errors = 0;

   nios_led_onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;

   // RAM model: words 0x100..0x2FF preloaded with 0xABCDE000|addr, everything else 0
   logic [31:0] mem_model [0:4095];
   initial begin
      for (int a = 0; a < 4096; a++) begin
         mem_model[a] = (a >= 256 && a < 768) ? (32'hABCDE000 | 32'(a)) : 32'h0;
      end
   end

   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
         end else begin
            mem_readdata <= mem_model[mem_address];
         end
      end
   end

   task automatic test_reset();
      reset_n = 1'b0; m0_read = 1'b1; m0_address = 12'h005;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait got %b want 1", m0_waitrequest); end
      checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait got %b want 1", m1_waitrequest); end
      checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", mem_chipselect); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %b want 0", mem_write); end
      checks++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0) begin errors++; $display("FAIL rst_m0_rd got %b/%h want 0/0", m0_readdatavalid, m0_readdata); end
      checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL rst_clken got %b want 1", mem_clken); end
      @(negedge clk); reset_n = 1'b1;
      #1;
      checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL notready_m0_wait got %b want 1", m0_waitrequest); end
      @(negedge clk); #1;
      checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL ready_m0_wait got %b want 0", m0_waitrequest); end
      checks++; if (mem_address !== 12'h005 || mem_chipselect !== 1'b1) begin errors++; $display("FAIL ready_addr got %h/%b want 005/1", mem_address, mem_chipselect); end
      @(negedge clk); m0_read = 1'b0;
      #1;
      checks++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL ready_rdv got %b%b want 10", m0_readdatavalid, m1_readdatavalid); end
      $display("txn reset release: m0 read @005 granted one edge after release");
   endtask

   task automatic test_write_read();
      @(negedge clk);
      m0_write = 1'b1; m0_address = 12'h010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      #1;
      checks++; if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_grant got wait=%b we=%b want 0/1", m0_waitrequest, mem_write); end
      checks++; if (mem_writedata !== 32'hDEADBEEF || mem_byteenable !== 4'hF) begin errors++; $display("FAIL wr_data got %h/%h want deadbeef/f", mem_writedata, mem_byteenable); end
      @(negedge clk);
      m0_write = 1'b0; m0_read = 1'b1; m0_writedata = '0;
      #1;
      checks++; if (m0_waitrequest !== 1'b0 || mem_write !== 1'b0 || mem_address !== 12'h010) begin errors++; $display("FAIL rd_accept got wait=%b we=%b a=%h want 0/0/010", m0_waitrequest, mem_write, mem_address); end
      @(negedge clk); m0_read = 1'b0;
      #1;
      checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_return got %b/%h want 1/deadbeef", m0_readdatavalid, m0_readdata); end
      checks++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0) begin errors++; $display("FAIL rd_nonowner got %b/%h want 0/0", m1_readdatavalid, m1_readdata); end
      @(negedge clk); #1;
      checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse got %b want 0", m0_readdatavalid); end
      $display("txn m0 write/read @010 data %h", 32'hDEADBEEF);
      // read and write together: serviced as a write, no read response
      @(negedge clk);
      m0_read = 1'b1; m0_write = 1'b1; m0_address = 12'h020; m0_writedata = 32'h12345678;
      #1;
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rw_is_write got %b want 1", mem_write); end
      @(negedge clk);
      m0_write = 1'b0; m0_writedata = '0;
      #1;
      checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv got %b want 0", m0_readdatavalid); end
      @(negedge clk); m0_read = 1'b0;
      #1;
      checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h12345678) begin errors++; $display("FAIL rw_readback got %b/%h want 1/12345678", m0_readdatavalid, m0_readdata); end
      $display("txn m0 read+write @020 treated as write");
   endtask

   task automatic test_byte_lanes();
      @(negedge clk);
      m1_write = 1'b1; m1_address = 12'hFFF; m1_writedata = 32'h11223344; m1_byteenable = 4'h3;
      #1;
      checks++; if (m1_waitrequest !== 1'b0 || mem_byteenable !== 4'h3 || mem_address !== 12'hFFF) begin errors++; $display("FAIL be_grant got wait=%b be=%h a=%h want 0/3/fff", m1_waitrequest, mem_byteenable, mem_address); end
      @(negedge clk);
      m1_write = 1'b0; m1_read = 1'b1;
      @(negedge clk); m1_read = 1'b0;
      #1;
      checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h00003344) begin errors++; $display("FAIL be_readback got %b/%h want 1/00003344", m1_readdatavalid, m1_readdata); end
      checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL be_nonowner got %b want 0", m0_readdatavalid); end
      @(negedge clk); #1;
      checks++; if (mem_chipselect !== 1'b0 || mem_address !== 12'h0 || mem_writedata !== 32'h0) begin errors++; $display("FAIL idle_mux got %b/%h/%h want 0/0/0", mem_chipselect, mem_address, mem_writedata); end
      $display("txn m1 write be=3 @fff, readback %h", 32'h00003344);
   endtask

   task automatic test_conflict();
      bit          exp0;
      logic [11:0] exp_addr;
      logic [31:0] exp_data;
      int          cnt0;
      int          cnt1;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         m0_read = 1'b1; m0_address = 12'(12'h100 + i);
         m1_read = 1'b1; m1_address = 12'(12'h200 + i);
         #1;
         exp0 = (i % 2 == 0);
         exp_addr = exp0 ? 12'(12'h100 + i) : 12'(12'h200 + i);
         checks++; if (m0_waitrequest !== !exp0 || m1_waitrequest !== exp0) begin errors++; $display("FAIL conf_grant%0d got wait=%b%b want %b%b", i, m0_waitrequest, m1_waitrequest, !exp0, exp0); end
         checks++; if (mem_address !== exp_addr) begin errors++; $display("FAIL conf_addr%0d got %h want %h", i, mem_address, exp_addr); end
         if (i > 0) begin
            exp_data = (i % 2 == 1) ? 32'(32'hABCDE100 + i - 1) : 32'(32'hABCDE200 + i - 1);
            if (i % 2 == 1) begin
               checks++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== exp_data) begin errors++; $display("FAIL conf_ret%0d got %b%b/%h want 10/%h", i, m0_readdatavalid, m1_readdatavalid, m0_readdata, exp_data); end
            end else begin
               checks++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== exp_data) begin errors++; $display("FAIL conf_ret%0d got %b%b/%h want 01/%h", i, m0_readdatavalid, m1_readdatavalid, m1_readdata, exp_data); end
            end
         end
         cnt0 += int'(m0_readdatavalid);
         cnt1 += int'(m1_readdatavalid);
      end
      @(negedge clk);
      m0_read = 1'b0; m1_read = 1'b0;
      #1;
      checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hABCDE205) begin errors++; $display("FAIL conf_last got %b/%h want 1/abcde205", m1_readdatavalid, m1_readdata); end
      cnt0 += int'(m0_readdatavalid);
      cnt1 += int'(m1_readdatavalid);
      checks++; if (cnt0 != 3 || cnt1 != 3) begin errors++; $display("FAIL conf_counts got %0d/%0d want 3/3", cnt0, cnt1); end
      $display("txn conflict 6 cycles: m0 pulses %0d m1 pulses %0d", cnt0, cnt1);
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      m1_read = 1'b1; m1_address = 12'h201;
      #1;
      checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_accept got %b want 0", m1_waitrequest); end
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      checks++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0) begin errors++; $display("FAIL mid_rdv got %b/%h want 0/0", m1_readdatavalid, m1_readdata); end
      checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL mid_outs got %b%b/%b want 11/0", m0_waitrequest, m1_waitrequest, mem_chipselect); end
      @(negedge clk); #1;
      checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_hold got %b want 0", m1_readdatavalid); end
      @(negedge clk);
      reset_n = 1'b1; m1_read = 1'b0;
      @(negedge clk); #1;
      checks++; if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_after got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
      $display("txn reset during m1 read @201: response suppressed");
   endtask

   task automatic test_arbitration();
      bit exp0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         m0_read = 1'b1; m0_address = 12'(12'h100 + i);
         m1_read = 1'b1; m1_address = 12'(12'h200 + i);
         #1;
`ifdef NIOS_LED_ARB_M0_PRIORITY_EN
         exp0 = 1'b1;
`else
         exp0 = (i % 2 == 0);
`endif
         checks++; if (m0_waitrequest !== !exp0 || m1_waitrequest !== exp0) begin errors++; $display("FAIL arb_grant%0d got wait=%b%b want %b%b", i, m0_waitrequest, m1_waitrequest, !exp0, exp0); end
      end
      @(negedge clk);
      m0_read = 1'b0;
      #1;
      checks++; if (m1_waitrequest !== 1'b0 || mem_address !== 12'h203) begin errors++; $display("FAIL arb_m0_idle got %b/%h want 0/203", m1_waitrequest, mem_address); end
      @(negedge clk);
      m1_read = 1'b0;
      repeat (2) @(negedge clk);
      $display("txn arbitration 4 conflict cycles then m1 alone");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_conflict();
      test_reset_mid_read();
      test_arbitration();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
